cy7c67200_irq_pio: RTL and testbench
====================================

Name: cy7c67200_irq_pio

Overview:
- Avalon-MM slave input PIO that brings the CY7C67200 interrupt lines (HPI_INT and related status pins) into the SOPC.
- Signals travel in the opposite direction to the existing CY7C67200 control output PIOs: pins into the CPU.
- Synchronises the pins, exposes their level, latches edges into a sticky capture register and raises a maskable level interrupt to the Nios II.

Parameters:
- WIDTH, 1, number of input pins (1..32).
- EDGE_TYPE, 2, edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any.
- SYNC_RESET_VALUE, all-ones (WIDTH bits), reset value of the synchroniser and previous-value registers. Matches the idle level of the active-low pins so no false edge is seen after reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits [WIDTH-1:0] used.
- in_port  in  WIDTH  asynchronous pins from the CY7C67200.
- readdata  out  32  read data; zero-extended above WIDTH.
- irq  out  1  level interrupt to the CPU, active-high.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high: sampled only on rising clk.
- Reset values:
  - sync1, sync2, prev = SYNC_RESET_VALUE.
  - irq_mask = 0.
  - edge_capture = 0.
  - irq = 0.
  - readdata follows the address decode of the reset values.
- Synchroniser: each cycle sync1 <= in_port, sync2 <= sync1, prev <= sync2.
- Edge detect, per bit, combinational from sync2 and prev:
  - rise = sync2 & ~prev.
  - fall = ~sync2 & prev.
  - any = sync2 ^ prev.
  - EDGE_TYPE selects which one is used as "edge".
- Register map (word address):
  - 0: data. RO: sync2. Writes ignored.
  - 1: reserved. Reads 0, writes ignored.
  - 2: irq_mask. RW, WIDTH bits.
  - 3: edge_capture. RO sticky. Writing 1 to a bit clears it (W1C); writing 0 leaves it unchanged.
- A write occurs when chipselect=1 and write_n=0 on a rising clk. It takes effect at that edge.
- Reads: read latency 0. readdata is a combinational mux of address over the registers, gated by nothing (chipselect is ignored for reads, same as our other PIOs). Bits [31:WIDTH] are always 0.
- Capture update per bit, evaluated each cycle: edge_capture[i] <= edge[i] | (edge_capture[i] & ~clr[i]).
  - clr[i] = write to address 3 with writedata[i] = 1.
  - Edge and clear in the same cycle: set wins. The bit stays 1 and the edge is never lost.
- irq = |(edge_capture & irq_mask), combinational from registers. It asserts in the same cycle as the capture or mask bit that causes it.
- Latency: a pin change that meets setup before clk edge k is visible in data (addr 0) after edge k+1. The capture bit and irq assert after edge k+2.
- Pulses on in_port shorter than one clk period may be missed; this is accepted. A pulse of at least 2 cycles is always captured.
- Masking:
  - Clearing a mask bit deasserts irq next cycle if no other bit is pending.
  - Setting a mask bit over an already-pending capture asserts irq immediately after the write edge.
- Reset asserted mid-operation clears capture and mask in that cycle and reloads the synchroniser to SYNC_RESET_VALUE. Pin edges during reset are discarded.
- If the pin is low when reset releases (pin not at its idle level), the first post-reset falling or any edge is captured after 2 cycles. This is intended.

Test Plan:
- Reset release, in_port held at 4'hF (WIDTH=4, EDGE_TYPE=2) -> irq=0, addr3 reads 0, addr0 reads 0x0000000F after 2 cycles, no capture.
- Mask 4'h1 (write addr2=0x1); drive in_port[0] 1->0 for 3 cycles -> addr3 reads 0x1 two cycles after the change, irq=1; write addr3=0x1 -> addr3=0, irq=0 next cycle.
- EDGE_TYPE=0; in_port[2] pulses 0->1->0 (4 cycles) with mask=0 -> addr3=0x4, irq stays 0; then write mask=0x4 -> irq=1 immediately after the write edge.
- W1C on bit 1 in the same cycle that a new edge on bit 1 reaches sync2/prev -> addr3 bit1 remains 1, irq remains asserted.
- Write addr3=0xE while bits 0 and 3 are pending (0x9) -> addr3 becomes 0x1; write addr0=0xFFFFFFFF -> no effect, data still tracks pins.
- Assert reset for 1 cycle with addr3=0xF, mask=0xF, irq=1 -> next cycle addr3=0, addr2=0, irq=0; in_port toggling during reset produces no capture.

Source files
------------

// File: rtl/cy7c67200_irq_pio.sv
//------------------------------------------------------------------------------
// cy7c67200_irq_pio : Avalon-MM input PIO with edge capture and maskable IRQ
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cy7c67200_irq_pio #(
  parameter int unsigned      WIDTH            = 1,
  parameter int unsigned      EDGE_TYPE        = 2,
  parameter logic [WIDTH-1:0] SYNC_RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAPT = 2'd3;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] capture_q;
  logic [WIDTH-1:0] capture_d;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic             w_we;
  logic             unused_wdata;

  // Only the low WIDTH bits of writedata carry register content.
  assign unused_wdata = ^writedata;

  assign w_we = chipselect & ~write_n;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign w_edge = sync2_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign w_edge = ~sync2_q & prev_q;
    end else begin : g_any
      assign w_edge = sync2_q ^ prev_q;
    end
  endgenerate

  always_comb begin
    mask_d = mask_q;
    w_clr  = '0;
    if (w_we && address == ADDR_MASK) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (w_we && address == ADDR_CAPT) begin
      w_clr = writedata[WIDTH-1:0];
    end
    // A new edge overrides a simultaneous clear so no event is lost.
    capture_d = w_edge | (capture_q & ~w_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= SYNC_RESET_VALUE;
      sync2_q   <= SYNC_RESET_VALUE;
      prev_q    <= SYNC_RESET_VALUE;
      mask_q    <= '0;
      capture_q <= '0;
    end else begin
      sync1_q   <= in_port;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      mask_q    <= mask_d;
      capture_q <= capture_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = sync2_q;
      ADDR_RSVD: readdata = '0;
      ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_CAPT: readdata[WIDTH-1:0] = capture_q;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(capture_q & mask_q);

endmodule

`default_nettype wire

// File: tb/tb_cy7c67200_irq_pio.sv
//------------------------------------------------------------------------------
// tb_cy7c67200_irq_pio : randomized self-checking bench, any-edge and rise-edge
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cy7c67200_irq_pio;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      rd_any;
  logic [31:0]      rd_rise;
  logic             irq_any;
  logic             irq_rise;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the last three pin samples, newest first.
  logic [WIDTH-1:0] m_hist [3];
  logic [WIDTH-1:0] m_mask;
  logic [WIDTH-1:0] m_cap_any;
  logic [WIDTH-1:0] m_cap_rise;

  always #5 clk = ~clk;

  cy7c67200_irq_pio #(.WIDTH(WIDTH), .EDGE_TYPE(2)) u_dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_any), .irq(irq_any)
  );

  cy7c67200_irq_pio #(.WIDTH(WIDTH), .EDGE_TYPE(0)) u_dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_rise), .irq(irq_rise)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the inputs the DUT will sample.
  task automatic step();
    logic             we;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] any_e;
    logic [WIDTH-1:0] rise_e;
    we  = chipselect && !write_n;
    clr = (we && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    if (reset) begin
      for (int i = 0; i < 3; i++) m_hist[i] = '1;
      m_mask     = '0;
      m_cap_any  = '0;
      m_cap_rise = '0;
    end else begin
      any_e  = m_hist[1] ^ m_hist[2];
      rise_e = m_hist[1] & ~m_hist[2];
      m_cap_any  = any_e  | (m_cap_any  & ~clr);
      m_cap_rise = rise_e | (m_cap_rise & ~clr);
      if (we && address == 2'd2) m_mask = writedata[WIDTH-1:0];
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = in_port;
    end
    @(posedge clk);
    #1;
  endtask

  // Drop the write strobe and compare every register and both IRQs.
  task automatic check_all();
    logic [31:0] exp_any;
    logic [31:0] exp_rise;
    chipselect = 1'b0;
    write_n    = 1'b1;
    check("irq_any",  {31'd0, irq_any},  {31'd0, |(m_cap_any & m_mask)});
    check("irq_rise", {31'd0, irq_rise}, {31'd0, |(m_cap_rise & m_mask)});
    for (int a = 0; a < 4; a++) begin
      address = a[1:0];
      #1;
      case (a)
        0:       begin exp_any = 32'(m_hist[1]);  exp_rise = 32'(m_hist[1]); end
        2:       begin exp_any = 32'(m_mask);     exp_rise = 32'(m_mask);    end
        3:       begin exp_any = 32'(m_cap_any);  exp_rise = 32'(m_cap_rise); end
        default: begin exp_any = 32'd0;           exp_rise = 32'd0;          end
      endcase
      check($sformatf("rd_any_a%0d", a),  rd_any,  exp_any);
      check($sformatf("rd_rise_a%0d", a), rd_rise, exp_rise);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_all();
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    check_all();
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    idle(2);
    reset = 1'b0;
    idle(3);

    // Falling edge on bit 0 with mask bit 0, then W1C.
    wr(2'd2, 32'h1);
    in_port = 4'hE;
    idle(3);
    check("cap_bit0_set", 32'(m_cap_any), 32'h1);
    wr(2'd3, 32'h1);
    in_port = 4'hF;
    idle(4);

    // Rising pulse on bit 2 while masked off, then unmask.
    wr(2'd2, 32'h0);
    wr(2'd3, 32'hF);
    in_port = 4'hB;
    idle(1);
    in_port = 4'hF;
    idle(4);
    in_port = 4'hB;
    idle(4);
    wr(2'd2, 32'h4);

    // Clear bit 1 in the same cycle its edge is visible: set must win.
    wr(2'd2, 32'hF);
    wr(2'd3, 32'hF);
    in_port = 4'hD;
    idle(2);
    wr(2'd3, 32'h2);
    check("set_wins", 32'(m_cap_any & 4'h2), 32'h2);

    // Partial W1C and ignored data write.
    idle(3);
    wr(2'd3, 32'hE);
    wr(2'd0, 32'hFFFF_FFFF);
    in_port = 4'h6;
    idle(4);

    // Reset mid-operation with pins toggling.
    reset   = 1'b1;
    in_port = 4'h0;
    idle(1);
    in_port = 4'h5;
    idle(1);
    reset   = 1'b0;
    in_port = 4'hF;
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = WIDTH'($urandom);
      reset = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0) begin
        address    = 2'($urandom);
        writedata  = $urandom;
        chipselect = 1'($urandom);
        write_n    = 1'b0;
      end
      step();
      check_all();
    end
    reset = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
